mem_resp_ram: RTL and testbench

- Responder end of the memcpy/util memory-access interface: single-port RAM slave serving addr/rd_ena/wr_ena requests from an initiator (memcpy engine or util port mux).
- Adds a registered read-data return with a valid strobe, programmable wait states, a busy back-pressure flag and an error flag, so initiators can be verified against a responder with real timing.
- Sits directly behind the address/enable mux that selects between the util path and memcpy.

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_resp_ram_array.sv | 35 +++
 rtl/mem_resp_ram.sv | 155 +++++++++++++++
 tb/tb_mem_resp_ram.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and default widths for the memory responder.
//   state_e : responder FSM states (IDLE, WAIT, ACCESS)
//   op_e    : latched operation kind (OP_RD, OP_WR)
package mem_resp_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

endpackage

// File: rtl/mem_resp_ram_array.sv
// ram_array: synchronous single-port storage, DEPTH x DATA_W, no reset.
//   clk  : clock
//   we   : write enable, mem[addr] <= din at the rising edge
//   re   : read enable, dout <= mem[addr] at the rising edge
//   addr : word index
//   din  : write data
//   dout : registered read data, holds between reads
module ram_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      if (re) begin
         dout_q <= mem_q[addr];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port RAM responder with wait states, busy
// back-pressure, registered read return and a request-error strobe.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   addr     : request word address
//   wr_data  : write data, sampled with the request
//   wr_ena   : write request
//   rd_ena   : read request
//   rd_data  : registered read data, holds its last value between reads
//   rd_valid : one-cycle strobe, rd_data carries a fresh read
//   busy     : request in flight, new requests are dropped
//   err      : one-cycle strobe, request rejected (both enables or addr >= DEPTH)
module mem_resp_ram
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_ena,
   input  logic              rd_ena,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
   localparam int WS_M1_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0] WS_M1 = WS_M1_I[3:0];

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_seen_q, rd_seen_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   op_e               op_q, op_d;

   logic              in_range;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_dout;

   // Zero-extend so DEPTH == 2**ADDR_W compares correctly.
   assign in_range = ({1'b0, addr} < DEPTH_L);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      err_d      = 1'b0;
      rd_valid_d = 1'b0;
      rd_seen_d  = rd_seen_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      op_d       = op_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((rd_ena ^ wr_ena) && in_range) begin
               addr_d  = addr[IDX_W-1:0];
               wdata_d = wr_data;
               op_d    = wr_ena ? OP_WR : OP_RD;
               busy_d  = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WS_M1;
               end else begin
                  state_d = ACCESS;
               end
            end else if (rd_ena || wr_ena) begin
               err_d = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            if (op_q == OP_WR) begin
               ram_we = 1'b1;
            end else begin
               ram_re     = 1'b1;
               rd_valid_d = 1'b1;
               rd_seen_d  = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_seen_q  <= rd_seen_d;
      end
   end

   // Request payload only matters once accepted, so it carries no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
   end

   ram_array #(
      .ADDR_W (IDX_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q),
      .din  (wdata_q),
      .dout (ram_dout)
   );

   // The storage output has no reset; rd_data reads as zero until the
   // first read after reset, then follows the registered RAM output.
   assign rd_data  = rd_seen_q ? ram_dout : '0;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_resp_ram.sv
module tb_mem_resp_ram;

   logic       clk = 1'b0;
   logic       rstn_s  [3];
   logic [7:0] addr_s  [3];
   logic [7:0] wdata_s [3];
   logic       wr_s    [3];
   logic       rd_s    [3];
   logic [7:0] rdata_s [3];
   logic       rdv_s   [3];
   logic       busy_s  [3];
   logic       err_s   [3];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // 0: WAIT_STATES=1 DEPTH=256, 1: WAIT_STATES=0 DEPTH=16, 2: WAIT_STATES=3 DEPTH=256
   mem_resp_ram #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1)) u_a (
      .clk(clk), .rst_n(rstn_s[0]), .addr(addr_s[0]), .wr_data(wdata_s[0]),
      .wr_ena(wr_s[0]), .rd_ena(rd_s[0]), .rd_data(rdata_s[0]),
      .rd_valid(rdv_s[0]), .busy(busy_s[0]), .err(err_s[0]));

   mem_resp_ram #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(0)) u_b (
      .clk(clk), .rst_n(rstn_s[1]), .addr(addr_s[1]), .wr_data(wdata_s[1]),
      .wr_ena(wr_s[1]), .rd_ena(rd_s[1]), .rd_data(rdata_s[1]),
      .rd_valid(rdv_s[1]), .busy(busy_s[1]), .err(err_s[1]));

   mem_resp_ram #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u_c (
      .clk(clk), .rst_n(rstn_s[2]), .addr(addr_s[2]), .wr_data(wdata_s[2]),
      .wr_ena(wr_s[2]), .rd_ena(rd_s[2]), .rd_data(rdata_s[2]),
      .rd_valid(rdv_s[2]), .busy(busy_s[2]), .err(err_s[2]));

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
      int         exp_busy;
      int         exp_err;
      int         exp_vat;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present one request for exactly one rising edge (edge N).
   task automatic req(input int idx, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      rd_s[idx]    = rd;
      wr_s[idx]    = wr;
      addr_s[idx]  = a;
      wdata_s[idx] = d;
      @(posedge clk);
      #1;
      rd_s[idx] = 1'b0;
      wr_s[idx] = 1'b0;
   endtask

   // Watch ws+3 falling edges after edge N; vat is the index of the
   // first rd_valid (0 = right after edge N), -1 if none.
   task automatic observe(input int idx, input int ws, input string tag,
                          output int nb, output int ne, output int vat);
      int nv;
      int both;
      nb = 0; ne = 0; nv = 0; vat = -1; both = 0;
      for (int k = 0; k < ws + 3; k++) begin
         @(negedge clk);
         if (busy_s[idx]) nb++;
         if (err_s[idx]) ne++;
         if (rdv_s[idx]) begin
            nv++;
            if (vat < 0) vat = k;
         end
         if (err_s[idx] && rdv_s[idx]) both++;
      end
      chk({tag, " err_and_valid"}, both, 0);
      if (vat >= 0) chk({tag, " valid_count"}, nv, 1);
   endtask

   task automatic do_req(input int idx, input int ws, input string tag,
                         input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d,
                         input int eb, input int ee, input int ev,
                         input logic [7:0] er);
      int nb, ne, vat;
      req(idx, rd, wr, a, d);
      observe(idx, ws, tag, nb, ne, vat);
      chk({tag, " busy_cycles"}, nb, eb);
      chk({tag, " err_cycles"}, ne, ee);
      chk({tag, " valid_at"}, vat, ev);
      chk({tag, " rd_data"}, int'(rdata_s[idx]), int'(er));
   endtask

   initial begin
      int nb, ne, vat, nv;

      for (int i = 0; i < 3; i++) begin
         rstn_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
         rd_s[i] = 1'b0; wr_s[i] = 1'b0;
      end

      vecs[0] = '{1'b0, 1'b1, 8'h03, 8'hA5, 2, 0, -1, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 8'h03, 8'h00, 2, 0,  2, 8'hA5};
      vecs[2] = '{1'b0, 1'b1, 8'h05, 8'h3C, 2, 0, -1, 8'hA5};
      vecs[3] = '{1'b1, 1'b1, 8'h05, 8'h77, 0, 1, -1, 8'hA5};
      vecs[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 2, 0,  2, 8'h3C};
      vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h81, 2, 0, -1, 8'h3C};
      vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2, 0,  2, 8'h81};
      vecs[7] = '{1'b0, 1'b0, 8'h10, 8'h22, 0, 0, -1, 8'h81};
      vecs[8] = '{1'b1, 1'b0, 8'h03, 8'h00, 2, 0,  2, 8'hA5};
      vecs[9] = '{1'b1, 1'b1, 8'h00, 8'h00, 0, 1, -1, 8'hA5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rstn_s[i] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset busy[%0d]", i), int'(busy_s[i]), 0);
         chk($sformatf("reset err[%0d]", i), int'(err_s[i]), 0);
         chk($sformatf("reset rd_valid[%0d]", i), int'(rdv_s[i]), 0);
         chk($sformatf("reset rd_data[%0d]", i), int'(rdata_s[i]), 0);
      end

      // Table-driven sequence on the one-wait-state instance.
      for (int v = 0; v < 10; v++) begin
         do_req(0, 1, $sformatf("ws1 vec%0d", v), vecs[v].rd, vecs[v].wr,
                vecs[v].a, vecs[v].d, vecs[v].exp_busy, vecs[v].exp_err,
                vecs[v].exp_vat, vecs[v].exp_rdata);
      end

      // Zero wait states: fill 0..7, then back-to-back reads every 2 cycles.
      for (int i = 0; i < 8; i++) begin
         do_req(1, 0, $sformatf("ws0 wr%0d", i), 1'b0, 1'b1, 8'(i), 8'(8'h10 + i),
                1, 0, -1, 8'h00);
      end
      nv = 0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            if (rdv_s[1]) nv++;
            chk($sformatf("b2b valid%0d", i - 1), int'(rdv_s[1]), 1);
            chk($sformatf("b2b data%0d", i - 1), int'(rdata_s[1]), 8'h10 + i - 1);
         end
         rd_s[1] = 1'b1; addr_s[1] = 8'(i);
         @(posedge clk);
         #1 rd_s[1] = 1'b0;
         @(negedge clk);
         chk($sformatf("b2b busy%0d", i), int'(busy_s[1]), 1);
         @(negedge clk);
      end
      if (rdv_s[1]) nv++;
      chk("b2b valid7", int'(rdv_s[1]), 1);
      chk("b2b data7", int'(rdata_s[1]), 8'h17);
      chk("b2b strobes", nv, 8);

      // Out-of-range addresses on the 16-word instance.
      do_req(1, 0, "oor addr20", 1'b1, 1'b0, 8'd20, 8'h00, 0, 1, -1, 8'h17);
      do_req(1, 0, "oor addr16", 1'b1, 1'b0, 8'd16, 8'h00, 0, 1, -1, 8'h17);
      do_req(1, 0, "inrange addr15 wr", 1'b0, 1'b1, 8'd15, 8'h9E, 1, 0, -1, 8'h17);
      do_req(1, 0, "inrange addr15 rd", 1'b1, 1'b0, 8'd15, 8'h00, 1, 0, 1, 8'h9E);

      // Three wait states: preload, then a write issued while busy is dropped.
      do_req(2, 3, "ws3 wr3", 1'b0, 1'b1, 8'd3, 8'hA5, 4, 0, -1, 8'h00);
      do_req(2, 3, "ws3 wr9", 1'b0, 1'b1, 8'd9, 8'h11, 4, 0, -1, 8'h00);
      req(2, 1'b1, 1'b0, 8'd3, 8'h00);
      nb = 0; vat = -1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busy_s[2]) nb++;
         if (rdv_s[2] && vat < 0) vat = k;
         if (k == 0) begin
            wr_s[2] = 1'b1; addr_s[2] = 8'd3; wdata_s[2] = 8'hFF;
         end else begin
            wr_s[2] = 1'b0;
         end
      end
      chk("ws3 drop busy_cycles", nb, 4);
      chk("ws3 drop valid_at", vat, 4);
      chk("ws3 drop rd_data", int'(rdata_s[2]), 8'hA5);
      do_req(2, 3, "ws3 reread3", 1'b1, 1'b0, 8'd3, 8'h00, 4, 0, 4, 8'hA5);

      // Reset during WAIT discards a pending write.
      req(2, 1'b0, 1'b1, 8'd9, 8'h5A);
      @(negedge clk);
      chk("rst pre busy", int'(busy_s[2]), 1);
      rstn_s[2] = 1'b0;
      #1;
      chk("rst busy", int'(busy_s[2]), 0);
      chk("rst err", int'(err_s[2]), 0);
      chk("rst rd_valid", int'(rdv_s[2]), 0);
      chk("rst rd_data", int'(rdata_s[2]), 0);
      repeat (5) @(negedge clk);
      rstn_s[2] = 1'b1;
      do_req(2, 3, "rst reread9", 1'b1, 1'b0, 8'd9, 8'h00, 4, 0, 4, 8'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
